unit_pipeline_control: RTL and testbench
========================================

Name: unit_pipeline_control

Overview:
Central stall/flush/run sequencer for the 5-stage MIPS pipeline that sits beside the forwarding unit. It detects load-use hazards that forwarding cannot cover and inserts one bubble for each. It flushes IF/ID on taken branches and jumps. It gates every pipeline register through a global enable that implements continuous run, single-step (debug unit) and HALT drain.

Parameters:
BITS_REGS, 5, register-index width
DRAIN_CYCLES, 4, enabled cycles after HALT leaves ID until the pipeline is empty (EX, MEM, WB, plus 1 margin)
BITS_COUNT, 16, width of the performance counters

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_IDEX_mem_read  in  1  instruction in EX is a load
i_IDEX_rt  in  BITS_REGS  load destination register in EX
i_IFID_rs  in  BITS_REGS  rs of the instruction in ID
i_IFID_rt  in  BITS_REGS  rt of the instruction in ID
i_branch_taken  in  1  branch or jump resolved taken in ID
i_halt_detect  in  1  HALT opcode decoded in ID
i_step_mode  in  1  1 = debug single-step mode
i_step_req  in  1  one-cycle pulse from the debug unit: advance one clock
o_pipe_en  out  1  global enable for all pipeline registers and PC
o_pc_write  out  1  PC update enable (ANDed with o_pipe_en downstream)
o_IFID_write  out  1  IF/ID load enable
o_IFID_flush  out  1  replace IF/ID contents with NOP
o_IDEX_bubble  out  1  zero the ID/EX control bits
o_halted  out  1  pipeline drained after HALT
o_stall_count  out  BITS_COUNT  load-use stall cycles
o_flush_count  out  BITS_COUNT  IF/ID flush cycles

Behaviour:
- Load-use hazard (combinational) = i_IDEX_mem_read AND i_IDEX_rt != 0 AND (i_IDEX_rt == i_IFID_rs OR i_IDEX_rt == i_IFID_rt).
- Hazard response in the same cycle: o_pc_write=0, o_IFID_write=0, o_IDEX_bubble=1. The hazard lasts one enabled cycle, because the load then moves to MEM.
- Taken branch with no hazard: o_IFID_flush=1 and o_pc_write=1.
- Hazard has priority over i_branch_taken and over i_halt_detect. The instruction held in ID re-evaluates on the next cycle.
- FSM states: RUN, IDLE, STEP, DRAIN, HALTED. All transitions are evaluated on the rising edge of i_clk.
- RUN: o_pipe_en=1.
  - Goes to DRAIN when i_halt_detect is high and there is no hazard. The drain counter loads DRAIN_CYCLES.
  - Otherwise goes to IDLE if i_step_mode=1.
- IDLE: o_pipe_en=0.
  - Goes to STEP on i_step_req.
  - Goes to RUN if i_step_mode=0.
  - If both are true, STEP wins.
- STEP: o_pipe_en=1 for exactly one cycle.
  - Goes to DRAIN on an unhazarded i_halt_detect.
  - Otherwise goes to IDLE if i_step_mode=1, else to RUN.
- Cycle that detects HALT: o_pc_write=0 and o_IFID_flush=1, so the instruction fetched after HALT is discarded.
- DRAIN: o_pc_write=0, o_IFID_flush=1, o_IFID_write=1.
  - o_pipe_en = i_step_mode ? i_step_req : 1.
  - The counter decrements only on cycles where o_pipe_en=1.
  - When the counter is 1 on an enabled cycle, the next state is HALTED.
- HALTED: o_pipe_en=0 and o_halted=1 (registered). This state exits only on i_reset.
- All hazard/flush outputs are qualified by state. In IDLE and HALTED, o_IDEX_bubble, o_IFID_flush, o_pc_write and o_IFID_write are 0.
- Reset:
  - While i_reset=1, o_pipe_en=0, o_pc_write=0 and o_IFID_write=0.
  - On the next edge: state=RUN, drain counter=0, o_halted=0, both counters=0.
  - Reset asserted mid-DRAIN or mid-STEP abandons that operation.
- Counters:
  - o_stall_count increments on cycles with hazard AND o_pipe_en=1.
  - o_flush_count increments on cycles with o_IFID_flush AND o_pipe_en=1.
  - Both saturate at all-ones; they do not wrap.

Optional Feature:
PERF_COUNTERS_EN: when defined, o_stall_count and o_flush_count are implemented as above. When undefined, both outputs are constant 0, no counter flops exist, and all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (3 bits: RUN, IDLE, STEP, DRAIN, HALTED) and the NOP/bubble constant.
- One natural sub-module, unit_sat_counter (BITS_COUNT wide, inputs inc and clear), instantiated twice under PERF_COUNTERS_EN.

Test Plan:
1. Load-use hazard:
   - Stimulus: lw with rt=8 in EX, ID reads rs=8.
   - Response: one cycle with o_pc_write=0, o_IFID_write=0, o_IDEX_bubble=1, o_stall_count=1.
   - Same setup with rt=0: no stall.
2. Hazard plus branch:
   - Stimulus: hazard and i_branch_taken in the same cycle, then branch alone next cycle.
   - Response: cycle 1 stalls with o_IFID_flush=0; cycle 2 has o_IFID_flush=1, o_flush_count=1.
3. HALT in RUN:
   - Stimulus: i_halt_detect for one cycle.
   - Response: o_pc_write=0 from that cycle; o_halted=1 exactly DRAIN_CYCLES+1 edges later; o_pipe_en=0 afterwards.
4. Single-step:
   - Stimulus: i_step_mode=1, then three i_step_req pulses spaced 5 cycles apart.
   - Response: o_pipe_en is high for exactly 3 single cycles.
   - Then drop i_step_mode: o_pipe_en=1 continuously.
5. Step-mode drain:
   - Stimulus: HALT detected in STEP.
   - Response: o_halted rises only after 4 further i_step_req pulses.
6. Reset and saturation:
   - Stimulus: i_reset asserted mid-DRAIN.
   - Response: next cycle state=RUN, o_halted=0, counters=0.
   - Forcing 65536 stall cycles leaves o_stall_count=16'hFFFF.

Source files
------------

// File: rtl/unit_pipeline_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unit_pipeline_control_pkg
//  Description : Shared definitions for the pipeline stall/flush/run
//                sequencer: FSM state encoding and the NOP/bubble word.
//  Revision    : 1.0 - initial release
// ============================================================================
package unit_pipeline_control_pkg;

    localparam int C_STATE_W = 3;

    typedef logic [C_STATE_W-1:0] state_t;

    localparam state_t C_ST_RUN    = 3'd0;
    localparam state_t C_ST_IDLE   = 3'd1;
    localparam state_t C_ST_STEP   = 3'd2;
    localparam state_t C_ST_DRAIN  = 3'd3;
    localparam state_t C_ST_HALTED = 3'd4;

    // All-zero instruction word: sll $0,$0,0, used as NOP / bubble
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/unit_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : unit_sat_counter
//  Description : Saturating up-counter with synchronous clear. Holds at
//                all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module unit_sat_counter #(
    parameter int BITS_COUNT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [BITS_COUNT-1:0] o_count
);

    logic [BITS_COUNT-1:0] count_q;
    logic [BITS_COUNT-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + BITS_COUNT'(1);
        end
    end

    // Count register
    always_ff @(posedge i_clk) begin
        count_q <= count_d;
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/unit_pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : unit_pipeline_control
//  Description : Stall/flush/run sequencer for the 5-stage MIPS pipeline.
//                Inserts a bubble on load-use hazards, flushes IF/ID on taken
//                branches, and gates all pipeline registers for continuous
//                run, debug single-step and HALT drain.
//                Build option: PERF_COUNTERS_EN enables the stall/flush
//                performance counters (outputs tie to zero otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module unit_pipeline_control
    import unit_pipeline_control_pkg::*;
#(
    parameter int BITS_REGS    = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int BITS_COUNT   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_IDEX_mem_read,
    input  logic [BITS_REGS-1:0]  i_IDEX_rt,
    input  logic [BITS_REGS-1:0]  i_IFID_rs,
    input  logic [BITS_REGS-1:0]  i_IFID_rt,
    input  logic                  i_branch_taken,
    input  logic                  i_halt_detect,
    input  logic                  i_step_mode,
    input  logic                  i_step_req,
    output logic                  o_pipe_en,
    output logic                  o_pc_write,
    output logic                  o_IFID_write,
    output logic                  o_IFID_flush,
    output logic                  o_IDEX_bubble,
    output logic                  o_halted,
    output logic [BITS_COUNT-1:0] o_stall_count,
    output logic [BITS_COUNT-1:0] o_flush_count
);

    localparam int C_DRAIN_W_RAW = $clog2(DRAIN_CYCLES + 1);
    localparam int C_DRAIN_W     = (C_DRAIN_W_RAW < 1) ? 1 : C_DRAIN_W_RAW;
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LOAD = C_DRAIN_W'(DRAIN_CYCLES);
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_ONE  = C_DRAIN_W'(1);

    state_t               state_q;
    state_t               state_d;
    logic [C_DRAIN_W-1:0] drain_q;
    logic [C_DRAIN_W-1:0] drain_d;
    logic                 halted_q;
    logic                 halted_d;

    logic                 w_hazard;
    logic                 w_drain_en;

    // Load-use hazard: a load in EX writes a register the ID instruction reads
    always_comb begin
        w_hazard = i_IDEX_mem_read
                && (i_IDEX_rt != '0)
                && ((i_IDEX_rt == i_IFID_rs) || (i_IDEX_rt == i_IFID_rt));
    end

    // Drain advances every cycle in run mode, only on step pulses in step mode
    always_comb begin
        w_drain_en = i_step_mode ? i_step_req : 1'b1;
    end

    // State, drain counter and halted flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= C_ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic; RUN and STEP leave the same way, STEP just lasts one cycle
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            C_ST_RUN, C_ST_STEP: begin
                if (i_halt_detect && !w_hazard) begin
                    state_d = C_ST_DRAIN;
                    drain_d = C_DRAIN_LOAD;
                end else if (i_step_mode) begin
                    state_d = C_ST_IDLE;
                end else begin
                    state_d = C_ST_RUN;
                end
            end
            C_ST_IDLE: begin
                if (i_step_req) begin
                    state_d = C_ST_STEP;
                end else if (!i_step_mode) begin
                    state_d = C_ST_RUN;
                end
            end
            C_ST_DRAIN: begin
                if (w_drain_en) begin
                    if (drain_q <= C_DRAIN_ONE) begin
                        state_d = C_ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - C_DRAIN_ONE;
                    end
                end
            end
            C_ST_HALTED: begin
                state_d = C_ST_HALTED;
            end
            default: begin
                state_d = C_ST_RUN;
                drain_d = '0;
            end
        endcase
        halted_d = (state_d == C_ST_HALTED);
    end

    // Output decode: hazard beats halt beats branch; reset forces everything off
    always_comb begin
        o_pipe_en     = 1'b0;
        o_pc_write    = 1'b0;
        o_IFID_write  = 1'b0;
        o_IFID_flush  = 1'b0;
        o_IDEX_bubble = 1'b0;
        if (!i_reset) begin
            case (state_q)
                C_ST_RUN, C_ST_STEP: begin
                    o_pipe_en = 1'b1;
                    if (w_hazard) begin
                        // Hold PC and IF/ID, send a bubble down to EX
                        o_IDEX_bubble = 1'b1;
                    end else if (i_halt_detect) begin
                        // Freeze PC and discard the instruction fetched after HALT
                        o_IFID_flush = 1'b1;
                        o_IFID_write = 1'b1;
                    end else if (i_branch_taken) begin
                        o_IFID_flush = 1'b1;
                        o_IFID_write = 1'b1;
                        o_pc_write   = 1'b1;
                    end else begin
                        o_IFID_write = 1'b1;
                        o_pc_write   = 1'b1;
                    end
                end
                C_ST_DRAIN: begin
                    o_pipe_en    = w_drain_en;
                    o_IFID_flush = 1'b1;
                    o_IFID_write = 1'b1;
                end
                default: begin
                    o_pipe_en = 1'b0;
                end
            endcase
        end
    end

    assign o_halted = halted_q;

`ifdef PERF_COUNTERS_EN
    logic w_stall_inc;
    logic w_flush_inc;

    // Count only cycles that actually advance the pipeline
    always_comb begin
        w_stall_inc = o_IDEX_bubble && o_pipe_en;
        w_flush_inc = o_IFID_flush && o_pipe_en;
    end

    unit_sat_counter #(
        .BITS_COUNT (BITS_COUNT)
    ) u_stall_counter (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_count)
    );

    unit_sat_counter #(
        .BITS_COUNT (BITS_COUNT)
    ) u_flush_counter (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_inc   (w_flush_inc),
        .o_count (o_flush_count)
    );
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unit_pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unit_pipeline_control
//  Description : Self-checking bench for unit_pipeline_control: directed
//                scenarios plus random traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_pipeline_control;

    localparam int BITS_REGS    = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int BITS_COUNT   = 16;
    localparam int CNT_MAX      = (1 << BITS_COUNT) - 1;

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_IDEX_mem_read = 1'b0;
    logic [BITS_REGS-1:0]  i_IDEX_rt = '0;
    logic [BITS_REGS-1:0]  i_IFID_rs = '0;
    logic [BITS_REGS-1:0]  i_IFID_rt = '0;
    logic                  i_branch_taken = 1'b0;
    logic                  i_halt_detect = 1'b0;
    logic                  i_step_mode = 1'b0;
    logic                  i_step_req = 1'b0;
    logic                  o_pipe_en;
    logic                  o_pc_write;
    logic                  o_IFID_write;
    logic                  o_IFID_flush;
    logic                  o_IDEX_bubble;
    logic                  o_halted;
    logic [BITS_COUNT-1:0] o_stall_count;
    logic [BITS_COUNT-1:0] o_flush_count;

    always #5 clk = ~clk;

    unit_pipeline_control #(
        .BITS_REGS    (BITS_REGS),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .BITS_COUNT   (BITS_COUNT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_IDEX_mem_read (i_IDEX_mem_read),
        .i_IDEX_rt       (i_IDEX_rt),
        .i_IFID_rs       (i_IFID_rs),
        .i_IFID_rt       (i_IFID_rt),
        .i_branch_taken  (i_branch_taken),
        .i_halt_detect   (i_halt_detect),
        .i_step_mode     (i_step_mode),
        .i_step_req      (i_step_req),
        .o_pipe_en       (o_pipe_en),
        .o_pc_write      (o_pc_write),
        .o_IFID_write    (o_IFID_write),
        .o_IFID_flush    (o_IFID_flush),
        .o_IDEX_bubble   (o_IDEX_bubble),
        .o_halted        (o_halted),
        .o_stall_count   (o_stall_count),
        .o_flush_count   (o_flush_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: the pipeline is either halted, draining with N
    // enabled cycles left, paused waiting for a step, or advancing.
    bit m_valid   = 1'b0;
    bit m_halted  = 1'b0;
    bit m_paused  = 1'b0;
    int m_drain   = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    logic last_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit mr, input int exrt, input int rs,
                               input int rt, input bit br, input bit halt,
                               input bit smode, input bit sreq);
        bit e_en, e_pc, e_ifw, e_fl, e_bub, haz;
        @(negedge clk);
        i_reset         = rst;
        i_IDEX_mem_read = mr;
        i_IDEX_rt       = exrt[BITS_REGS-1:0];
        i_IFID_rs       = rs[BITS_REGS-1:0];
        i_IFID_rt       = rt[BITS_REGS-1:0];
        i_branch_taken  = br;
        i_halt_detect   = halt;
        i_step_mode     = smode;
        i_step_req      = sreq;
        #1;
        haz   = mr && (exrt != 0) && (exrt == rs || exrt == rt);
        e_en  = 0; e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0;
        if (rst || m_halted || (m_paused && m_drain == 0)) begin
            // everything off
        end else if (m_drain > 0) begin
            e_en = smode ? sreq : 1'b1;
            e_fl = 1; e_ifw = 1;
        end else begin
            e_en = 1;
            if (haz) e_bub = 1;
            else if (halt) begin e_fl = 1; e_ifw = 1; end
            else if (br) begin e_fl = 1; e_ifw = 1; e_pc = 1; end
            else begin e_ifw = 1; e_pc = 1; end
        end
        last_en = o_pipe_en;
        check_eq("pipe_en",     32'(o_pipe_en),     32'(e_en));
        check_eq("pc_write",    32'(o_pc_write),    32'(e_pc));
        check_eq("IFID_write",  32'(o_IFID_write),  32'(e_ifw));
        check_eq("IFID_flush",  32'(o_IFID_flush),  32'(e_fl));
        check_eq("IDEX_bubble", 32'(o_IDEX_bubble), 32'(e_bub));
        if (m_valid) begin
            check_eq("halted",      32'(o_halted),      32'(m_halted));
            check_eq("stall_count", 32'(o_stall_count), 32'(m_stalls));
            check_eq("flush_count", 32'(o_flush_count), 32'(m_flushes));
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_halted = 0; m_paused = 0; m_drain = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
`ifdef PERF_COUNTERS_EN
            if (e_en && e_bub && m_stalls < CNT_MAX) m_stalls++;
            if (e_en && e_fl && m_flushes < CNT_MAX) m_flushes++;
`endif
            if (m_halted) begin
                // only reset leaves
            end else if (m_drain > 0) begin
                if (e_en) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1;
                end
            end else if (m_paused) begin
                if (sreq || !smode) m_paused = 0;
            end else begin
                if (halt && !haz) m_drain = DRAIN_CYCLES;
                else if (smode) m_paused = 1;
            end
        end
    endtask

    task automatic nop_cycle(input bit smode);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, smode, 0);
    endtask

    initial begin
        int en_count;
        bit r_smode;

        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: lw rt=8 in EX, ID reads rs=8; then rt=0 never stalls
        drive_cycle(0, 1, 8, 8, 3, 0, 0, 0, 0);
        nop_cycle(0);
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
`ifdef PERF_COUNTERS_EN
        check_eq("t1_stall_count", 32'(o_stall_count), 32'd1);
`else
        check_eq("t1_stall_count", 32'(o_stall_count), 32'd0);
`endif

        // Hazard together with a taken branch, then the branch alone
        drive_cycle(0, 1, 9, 1, 9, 1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop_cycle(0);

        // HALT in RUN: halted appears DRAIN_CYCLES+1 edges after detection
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DRAIN_CYCLES - 1; i++) nop_cycle(0);
        #1 check_eq("t3_halted_early", 32'(o_halted), 32'd0);
        nop_cycle(0);
        #1 check_eq("t3_halted", 32'(o_halted), 32'd1);
        for (int i = 0; i < 3; i++) nop_cycle(0);

        // Single-step: three pulses five cycles apart give three enabled cycles
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop_cycle(1);
        en_count = 0;
        for (int i = 0; i < 15; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, (i % 5) == 2);
            if (last_en) en_count++;
        end
        check_eq("t4_step_en_count", 32'(en_count), 32'd3);
        for (int i = 0; i < 4; i++) nop_cycle(0);

        // HALT reached in STEP: drain needs four further step pulses
        nop_cycle(1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int p = 0; p < 4; p++) begin
            nop_cycle(1);
            nop_cycle(1);
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
            #1;
            if (p == 2) check_eq("t5_halted_early", 32'(o_halted), 32'd0);
            if (p == 3) check_eq("t5_halted", 32'(o_halted), 32'd1);
        end

        // Reset in the middle of a drain abandons it
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop_cycle(0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("t6_halted_after_reset", 32'(o_halted), 32'd0);
        check_eq("t6_flush_after_reset", 32'(o_flush_count), 32'd0);
        nop_cycle(0);
        nop_cycle(0);

        // Random traffic
        r_smode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) r_smode = ~r_smode;
            drive_cycle($urandom_range(0, 199) == 0,
                        $urandom_range(0, 1),
                        $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 3) == 0,
                        $urandom_range(0, 39) == 0,
                        r_smode,
                        $urandom_range(0, 3) == 0);
        end

`ifdef PERF_COUNTERS_EN
        // Saturation: more stall cycles than the counter can hold
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 5; i++) drive_cycle(0, 1, 8, 8, 0, 0, 0, 0, 0);
        #1 check_eq("t6_stall_saturated", 32'(o_stall_count), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
